// File: rtl/ctrl_mem_pkg.sv
// Shared types and constants for the 16x16 memory request sequencer.
package ctrl_mem_pkg;

  localparam int ANCHO_DATO_DEF = 16;
  localparam int ANCHO_DIR_DEF  = 16;

  // Returned in place of memory data when an address lies outside the array
  localparam logic [15:0] PATRON_ERROR = 16'hDEAD;

  typedef enum logic [1:0] {
    REPOSO,
    ESCRITURA,
    LECTURA,
    ESPERA
  } estado_t;

endpackage

// File: rtl/controlador_memoria_16x16.sv
// Valid/ready request sequencer that drives the 16x16 memory strobes and returns read data.
// Optional macro CTRL_MEM_RANGO_EN adds address range checking and the sticky Error_Rango output.
module controlador_memoria_16x16
  import ctrl_mem_pkg::*;
#(
  parameter int ANCHO_DATO  = ANCHO_DATO_DEF,
  parameter int ANCHO_DIR   = ANCHO_DIR_DEF,
  parameter int PALABRAS    = 16,
  parameter int LAT_LECTURA = 1
) (
  input  logic                  Reloj,
  input  logic                  Reinicio_n,
  input  logic                  Sol_Valida,
  output logic                  Sol_Lista,
  input  logic                  Sol_Escribir,
  input  logic [ANCHO_DIR-1:0]  Sol_Direccion,
  input  logic [ANCHO_DATO-1:0] Sol_Dato,
  output logic                  Rta_Valida,
  input  logic                  Rta_Lista,
  output logic [ANCHO_DATO-1:0] Rta_Dato,
  output logic                  Esc_Hecho,
  output logic                  Leer,
  output logic                  Escribir,
  output logic [ANCHO_DIR-1:0]  Direccion,
  output logic [ANCHO_DATO-1:0] Dato2M,
`ifdef CTRL_MEM_RANGO_EN
  output logic                  Error_Rango,
`endif
  input  logic [ANCHO_DATO-1:0] Rta
);

  if (LAT_LECTURA < 1 || LAT_LECTURA > 7 || PALABRAS < 1) begin : g_param_check
    $error("controlador_memoria_16x16: LAT_LECTURA must be 1..7 and PALABRAS >= 1");
  end

  estado_t     estado, estado_sig;
  logic [2:0]  contador;
  logic        fuera;
  logic        fuera_q;
  logic        acepta;
  logic        listo_dato;

`ifdef CTRL_MEM_RANGO_EN
  assign fuera = (Sol_Direccion >= ANCHO_DIR'(PALABRAS));
`else
  assign fuera = 1'b0;
`endif

  assign Sol_Lista = (estado == REPOSO) && !Rta_Valida;
  assign acepta    = Sol_Valida && Sol_Lista;

  // The memory samples Leer on the edge that drops it; latency is counted from there,
  // so the counter holds while Leer is still high.
  assign listo_dato = (estado == ESPERA) && !Leer && (contador == 3'd1);

  always_ff @(posedge Reloj or negedge Reinicio_n) begin
    if (!Reinicio_n) estado <= REPOSO;
    else             estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO: begin
        if (acepta) begin
          if (Sol_Escribir) estado_sig = ESCRITURA;
          else if (fuera)   estado_sig = ESPERA;
          else              estado_sig = LECTURA;
        end
      end
      ESCRITURA: estado_sig = REPOSO;
      LECTURA:   estado_sig = ESPERA;
      ESPERA:    if (listo_dato) estado_sig = REPOSO;
      default:   estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge Reloj or negedge Reinicio_n) begin
    if (!Reinicio_n) begin
      Leer       <= 1'b0;
      Escribir   <= 1'b0;
      Esc_Hecho  <= 1'b0;
      Rta_Valida <= 1'b0;
      Direccion  <= '0;
      Dato2M     <= '0;
      Rta_Dato   <= '0;
      contador   <= '0;
      fuera_q    <= 1'b0;
`ifdef CTRL_MEM_RANGO_EN
      Error_Rango <= 1'b0;
`endif
    end else begin
      Leer      <= (estado == LECTURA);
      Escribir  <= (estado == ESCRITURA) && !fuera_q;
      Esc_Hecho <= (estado == ESCRITURA) && !fuera_q;

      if (acepta) begin
        Direccion <= Sol_Direccion;
        Dato2M    <= Sol_Dato;
        fuera_q   <= fuera;
      end

      // An out-of-range read skips the memory and answers on the next edge
      if (estado == LECTURA)
        contador <= 3'(LAT_LECTURA);
      else if (acepta && fuera && !Sol_Escribir)
        contador <= 3'd1;
      else if ((estado == ESPERA) && !Leer)
        contador <= contador - 3'd1;

      if (listo_dato) begin
        Rta_Dato   <= fuera_q ? ANCHO_DATO'(PATRON_ERROR) : Rta;
        Rta_Valida <= 1'b1;
      end else if (Rta_Lista) begin
        Rta_Valida <= 1'b0;
      end

`ifdef CTRL_MEM_RANGO_EN
      if (acepta && fuera) Error_Rango <= 1'b1;
`endif
    end
  end

endmodule
